// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-client arbiter in front of the single Avalon-MM SDRAM controller slave
//   (new_sdram_controller_0_s1). A record-path writer and a playback-path reader
//   share the SDRAM. One command is in flight on the bus at a time. Pipelined
//   reads are counted and their data is routed back to the reader in issue order.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_wr_req/addr/data        writer request (held until o_wr_ack)
//   o_wr_ack                  one-cycle pulse: write accepted by the SDRAM
//   i_rd_req/addr             reader request (held until o_rd_ack)
//   o_rd_ack                  one-cycle pulse: read command accepted
//   o_rd_data, o_rd_valid     returned read data and its one-cycle strobe
//   o_avm_*                   Avalon-MM master towards the SDRAM controller
//   i_avm_readdata/valid      read return from the slave
//   i_avm_waitrequest         slave stall
//
// Build option
//   SDRAM_ARB_WRPRIO_EN  defined: strict write priority on a tie.
//                        undefined: round-robin on a tie.

`timescale 1ns/1ps

module sdram_arbiter #(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_chipselect,
    output logic [3:0]        o_avm_byteenable_n,
    output logic              o_avm_read_n,
    output logic              o_avm_write_n,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_readdatavalid,
    input  logic              i_avm_waitrequest
);

    localparam int unsigned      PendW   = $clog2(MAX_PEND + 1);
    localparam logic [PendW-1:0] PendMax = PendW'(MAX_PEND);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e            state_q, state_d;
    logic [PendW-1:0]  pend_q, pend_d;
    logic              ack_cycle, wr_elig, rd_elig, pick_wr, grant_wr, grant_rd;
    logic              rd_accept, rd_return;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] writedata_d;
    logic              read_n_d, write_n_d, wr_ack_d, rd_ack_d;

`ifdef SDRAM_ARB_WRPRIO_EN
    assign pick_wr = 1'b1;
`else
    logic last_rd_q, last_rd_d;  // 1: the most recent grant went to the reader
    assign pick_wr = last_rd_q;
`endif

    assign o_avm_chipselect   = 1'b1;
    assign o_avm_byteenable_n = 4'b0000;

    // During the ack cycle the client still shows the request that was just
    // served, so no grant is made then; this also spaces grants 3 cycles apart.
    assign ack_cycle = o_wr_ack | o_rd_ack;
    assign wr_elig   = i_wr_req & ~ack_cycle;
    assign rd_elig   = i_rd_req & ~ack_cycle & (pend_q < PendMax);
    assign grant_wr  = (state_q == StIdle) & wr_elig & (~rd_elig | pick_wr);
    assign grant_rd  = (state_q == StIdle) & rd_elig & ~grant_wr;

    assign rd_accept = (state_q == StRd) & ~i_avm_waitrequest;
    // Returns with nothing outstanding are stale or spurious and are dropped.
    assign rd_return = i_avm_readdatavalid & (pend_q != '0);

    always_comb begin
        unique case ({rd_accept, rd_return})
            2'b10:   pend_d = pend_q + PendW'(1);
            2'b01:   pend_d = pend_q - PendW'(1);
            default: pend_d = pend_q;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d = StWr;
                end else if (grant_rd) begin
                    state_d = StRd;
                end
            end
            StWr, StRd: begin
                if (!i_avm_waitrequest) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next-values; everything leaves the block through a register.
    always_comb begin
        address_d   = o_avm_address;
        writedata_d = o_avm_writedata;
        read_n_d    = o_avm_read_n;
        write_n_d   = o_avm_write_n;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
`ifndef SDRAM_ARB_WRPRIO_EN
        last_rd_d   = last_rd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    address_d   = i_wr_addr;
                    writedata_d = i_wr_data;
                    write_n_d   = 1'b0;
`ifndef SDRAM_ARB_WRPRIO_EN
                    last_rd_d   = 1'b0;
`endif
                end else if (grant_rd) begin
                    address_d = i_rd_addr;
                    read_n_d  = 1'b0;
`ifndef SDRAM_ARB_WRPRIO_EN
                    last_rd_d = 1'b1;
`endif
                end
            end
            StWr: begin
                if (!i_avm_waitrequest) begin
                    write_n_d = 1'b1;
                    wr_ack_d  = 1'b1;
                end
            end
            StRd: begin
                if (!i_avm_waitrequest) begin
                    read_n_d = 1'b1;
                    rd_ack_d = 1'b1;
                end
            end
            default: begin
                read_n_d  = 1'b1;
                write_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_avm_address   <= '0;
            o_avm_writedata <= '0;
            o_avm_read_n    <= 1'b1;
            o_avm_write_n   <= 1'b1;
            o_wr_ack        <= 1'b0;
            o_rd_ack        <= 1'b0;
            o_rd_valid      <= 1'b0;
            o_rd_data       <= '0;
            pend_q          <= '0;
`ifndef SDRAM_ARB_WRPRIO_EN
            last_rd_q       <= 1'b1;
`endif
        end else begin
            o_avm_address   <= address_d;
            o_avm_writedata <= writedata_d;
            o_avm_read_n    <= read_n_d;
            o_avm_write_n   <= write_n_d;
            o_wr_ack        <= wr_ack_d;
            o_rd_ack        <= rd_ack_d;
            o_rd_valid      <= rd_return;
            pend_q          <= pend_d;
            if (rd_return) begin
                o_rd_data <= i_avm_readdata;
            end
`ifndef SDRAM_ARB_WRPRIO_EN
            last_rd_q       <= last_rd_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps

module tb_sdram_arbiter;

    localparam int unsigned ADDR_W   = 23;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_PEND = 4;
    localparam byte         GW       = 8'h57;  // 'W'
    localparam byte         GR       = 8'h52;  // 'R'

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_wr_req = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [DATA_W-1:0] i_wr_data = '0;
    logic              o_wr_ack;
    logic              i_rd_req = 1'b0;
    logic [ADDR_W-1:0] i_rd_addr = '0;
    logic              o_rd_ack;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic [ADDR_W-1:0] o_avm_address;
    logic              o_avm_chipselect;
    logic [3:0]        o_avm_byteenable_n;
    logic              o_avm_read_n;
    logic              o_avm_write_n;
    logic [DATA_W-1:0] o_avm_writedata;
    logic [DATA_W-1:0] i_avm_readdata = '0;
    logic              i_avm_readdatavalid = 1'b0;
    logic              i_avm_waitrequest = 1'b0;

    sdram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_PEND(MAX_PEND)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_wr_req           (i_wr_req),
        .i_wr_addr          (i_wr_addr),
        .i_wr_data          (i_wr_data),
        .o_wr_ack           (o_wr_ack),
        .i_rd_req           (i_rd_req),
        .i_rd_addr          (i_rd_addr),
        .o_rd_ack           (o_rd_ack),
        .o_rd_data          (o_rd_data),
        .o_rd_valid         (o_rd_valid),
        .o_avm_address      (o_avm_address),
        .o_avm_chipselect   (o_avm_chipselect),
        .o_avm_byteenable_n (o_avm_byteenable_n),
        .o_avm_read_n       (o_avm_read_n),
        .o_avm_write_n      (o_avm_write_n),
        .o_avm_writedata    (o_avm_writedata),
        .i_avm_readdata     (i_avm_readdata),
        .i_avm_readdatavalid(i_avm_readdatavalid),
        .i_avm_waitrequest  (i_avm_waitrequest)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_item_t;

    typedef struct packed {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    int checks = 0;
    int failures = 0;

    // Stimulus queues (clients) and scoreboards (monitor)
    wr_item_t          wr_todo[$];
    wr_item_t          wr_exp[$];
    logic [ADDR_W-1:0] rd_todo[$];
    logic [ADDR_W-1:0] rd_addr_exp[$];
    logic [DATA_W-1:0] rd_data_exp[$];
    ret_t              pipe[$];
    byte               grant_log[$];
    logic [DATA_W-1:0] mem[int];

    // Slave behaviour knobs
    int wait_pct   = 0;
    int stall_cfg  = 0;
    bit hold_wait  = 0;
    int rd_lat     = 1;
    bit rand_lat   = 0;
    int ret_budget = -1;
    bit spurious   = 0;
    bit rand_gap   = 0;

    int                cyc = 0;
    int                model_pend = 0;
    int                wr_ack_cnt = 0;
    int                rd_ack_cnt = 0;
    int                rd_valid_cnt = 0;
    int                last_cmd_len = 0;
    logic [DATA_W-1:0] last_rd_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input longint act, input longint exp);
        checks++;
        failures++;
        $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Memory image seen by the slave: explicit entries, otherwise a hash of the address.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic int count_g(input byte g);
        int n = 0;
        foreach (grant_log[i]) if (grant_log[i] == g) n++;
        return n;
    endfunction

    // Writer client: holds the request until acked, then moves to the next item.
    initial begin : writer
        wr_item_t it;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                i_wr_req = 1'b0;
                continue;
            end
            if (i_wr_req && !o_wr_ack) continue;
            if (wr_todo.size() > 0 && !(rand_gap && $urandom_range(3) == 0)) begin
                it = wr_todo.pop_front();
                wr_exp.push_back(it);
                i_wr_req  = 1'b1;
                i_wr_addr = it.addr;
                i_wr_data = it.data;
            end else begin
                i_wr_req = 1'b0;
            end
        end
    end

    // Reader client
    initial begin : reader
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                i_rd_req = 1'b0;
                continue;
            end
            if (i_rd_req && !o_rd_ack) continue;
            if (rd_todo.size() > 0 && !(rand_gap && $urandom_range(3) == 0)) begin
                a = rd_todo.pop_front();
                rd_addr_exp.push_back(a);
                rd_data_exp.push_back(mem_word(a));
                i_rd_req  = 1'b1;
                i_rd_addr = a;
            end else begin
                i_rd_req = 1'b0;
            end
        end
    end

    // Slave model + monitor: outputs are sampled on the falling edge, the slave
    // decides waitrequest/readdatavalid for the next rising edge.
    logic              prev_wr_n = 1'b1, prev_rd_n = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    bit                exp_wr_ack = 0, exp_rd_ack = 0;
    int                since_start = 100;
    int                stall_left = 0;

    always @(negedge i_clk) begin : monitor
        logic     cmd_wr, cmd_rd, acc;
        wr_item_t it;
        ret_t     r;
        int       lat;
        cyc++;
        if (i_rst) begin
            prev_wr_n           = 1'b1;
            prev_rd_n           = 1'b1;
            exp_wr_ack          = 0;
            exp_rd_ack          = 0;
            stall_left          = 0;
            since_start         = 100;
            i_avm_readdatavalid = 1'b0;
            i_avm_waitrequest   = 1'b0;
        end else begin
            cmd_wr = !o_avm_write_n;
            cmd_rd = !o_avm_read_n;
            if (o_wr_ack || exp_wr_ack) check("wr_ack_timing", 64'(o_wr_ack), 64'(exp_wr_ack));
            if (o_rd_ack || exp_rd_ack) check("rd_ack_timing", 64'(o_rd_ack), 64'(exp_rd_ack));
            if (o_wr_ack) wr_ack_cnt++;
            if (o_rd_ack) rd_ack_cnt++;
            if (o_rd_valid) begin
                rd_valid_cnt++;
                last_rd_data = o_rd_data;
                if (rd_data_exp.size() == 0) flag("rd_valid_unexpected", longint'(o_rd_data), 0);
                else check("rd_data", 64'(o_rd_data), 64'(rd_data_exp.pop_front()));
            end
            if (cmd_wr && cmd_rd) flag("both_strobes_low", 2, 1);
            since_start++;
            if ((cmd_wr && prev_wr_n) || (cmd_rd && prev_rd_n)) begin
                check("grant_spacing", 64'(since_start >= 3), 64'(1));
                since_start  = 0;
                last_cmd_len = 1;
                grant_log.push_back(cmd_wr ? GW : GR);
                if (cmd_rd) check("rd_grant_under_max_pend", 64'(model_pend < MAX_PEND), 64'(1));
                stall_left = stall_cfg;
            end else if (cmd_wr || cmd_rd) begin
                last_cmd_len++;
                check("cmd_stable_during_wait",
                      64'({o_avm_address, o_avm_writedata, o_avm_write_n, o_avm_read_n}),
                      64'({prev_addr, prev_data, prev_wr_n, prev_rd_n}));
            end

            if (hold_wait) begin
                i_avm_waitrequest = 1'b1;
            end else if ((cmd_wr || cmd_rd) && stall_left > 0) begin
                i_avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                i_avm_waitrequest = ($urandom_range(99) < wait_pct);
            end

            acc        = (cmd_wr || cmd_rd) && !i_avm_waitrequest;
            exp_wr_ack = acc && cmd_wr;
            exp_rd_ack = acc && cmd_rd;
            if (acc && cmd_wr) begin
                if (wr_exp.size() == 0) begin
                    flag("wr_cmd_unexpected", longint'(o_avm_address), 0);
                end else begin
                    it = wr_exp.pop_front();
                    check("wr_addr", 64'(o_avm_address), 64'(it.addr));
                    check("wr_data", 64'(o_avm_writedata), 64'(it.data));
                end
            end
            if (acc && cmd_rd) begin
                if (rd_addr_exp.size() == 0) flag("rd_cmd_unexpected", longint'(o_avm_address), 0);
                else check("rd_addr", 64'(o_avm_address), 64'(rd_addr_exp.pop_front()));
                lat = rand_lat ? int'($urandom_range(5, 1)) : rd_lat;
                r.due  = cyc + lat;
                r.data = mem_word(o_avm_address);
                pipe.push_back(r);
                model_pend++;
            end

            i_avm_readdata      = $urandom;
            i_avm_readdatavalid = 1'b0;
            if (spurious) begin
                i_avm_readdatavalid = 1'b1;
            end else if (pipe.size() > 0 && pipe[0].due <= cyc && ret_budget != 0) begin
                r = pipe.pop_front();
                i_avm_readdata      = r.data;
                i_avm_readdatavalid = 1'b1;
                model_pend--;
                if (ret_budget > 0) ret_budget--;
            end

            prev_wr_n = o_avm_write_n;
            prev_rd_n = o_avm_read_n;
            prev_addr = o_avm_address;
            prev_data = o_avm_writedata;
        end
    end

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_item_t it;
        it.addr = a;
        it.data = d;
        wr_todo.push_back(it);
    endtask

    task automatic wait_drain(input string name, input int limit, input bit incl_data);
        int n = 0;
        while ((wr_todo.size() > 0 || rd_todo.size() > 0 || i_wr_req || i_rd_req ||
                wr_exp.size() > 0 || rd_addr_exp.size() > 0 ||
                (incl_data && rd_data_exp.size() > 0)) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= limit) flag({name, "_drain_timeout"}, n, limit);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic at_pos();
        @(posedge i_clk);
        #1;
    endtask

    initial begin : main
        int    base_w, base_r, base_v, n;
        string pat;

        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_read_n", 64'(o_avm_read_n), 64'(1));
        check("rst_write_n", 64'(o_avm_write_n), 64'(1));
        check("rst_address", 64'(o_avm_address), 64'(0));
        check("rst_writedata", 64'(o_avm_writedata), 64'(0));
        check("rst_acks", 64'({o_wr_ack, o_rd_ack}), 64'(0));
        check("rst_rd_valid", 64'(o_rd_valid), 64'(0));
        check("rst_rd_data", 64'(o_rd_data), 64'(0));
        check("chipselect", 64'(o_avm_chipselect), 64'(1));
        check("byteenable_n", 64'(o_avm_byteenable_n), 64'(0));
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Single write, no wait states
        at_pos();
        base_w = wr_ack_cnt;
        push_wr(23'h000010, 32'hAAAA5555);
        wait_drain("t1", 50, 1);
        check("t1_wr_ack_count", 64'(wr_ack_cnt - base_w), 64'(1));
        check("t1_cmd_len", 64'(last_cmd_len), 64'(1));
        check("t1_idle_strobes", 64'({o_avm_write_n, o_avm_read_n}), 64'(2'b11));

        // Write stalled by waitrequest for 5 cycles
        at_pos();
        stall_cfg = 5;
        base_w    = wr_ack_cnt;
        push_wr(23'h001234, 32'hDEADBEEF);
        wait_drain("t2", 60, 1);
        stall_cfg = 0;
        check("t2_wr_ack_count", 64'(wr_ack_cnt - base_w), 64'(1));
        check("t2_cmd_len", 64'(last_cmd_len), 64'(6));

        // Single read returning three cycles after acceptance
        at_pos();
        rd_lat = 3;
        mem[int'(23'h000ABC)] = 32'h12345678;
        base_r = rd_ack_cnt;
        base_v = rd_valid_cnt;
        rd_todo.push_back(23'h000ABC);
        wait_drain("t3", 60, 1);
        rd_lat = 1;
        check("t3_rd_ack_count", 64'(rd_ack_cnt - base_r), 64'(1));
        check("t3_rd_valid_count", 64'(rd_valid_cnt - base_v), 64'(1));
        check("t3_rd_data", 64'(last_rd_data), 64'(32'h12345678));

        // Both clients held for 8 grants; the last grant so far was a read
        at_pos();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_wr(ADDR_W'($urandom), $urandom);
            rd_todo.push_back(ADDR_W'($urandom));
        end
        wait_drain("t4", 200, 1);
`ifdef SDRAM_ARB_WRPRIO_EN
        pat = "WWWWRRRR";
`else
        pat = "WRWRWRWR";
`endif
        check("t4_grant_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check($sformatf("t4_grant_%0d", i), 64'(grant_log[i]), 64'(pat[i]));
        end

        // Outstanding-read limit with returns held back
        at_pos();
        ret_budget = 0;
        grant_log.delete();
        for (int i = 0; i < 6; i++) rd_todo.push_back(ADDR_W'($urandom));
        repeat (40) @(negedge i_clk);
        check("t5_reads_at_limit", 64'(count_g(GR)), 64'(MAX_PEND));
        at_pos();
        push_wr(23'h007777, 32'h0F0F_F0F0);
        repeat (20) @(negedge i_clk);
        check("t5_write_served_at_limit", 64'(count_g(GW)), 64'(1));
        check("t5_reads_still_blocked", 64'(count_g(GR)), 64'(MAX_PEND));
        at_pos();
        ret_budget = 1;
        repeat (20) @(negedge i_clk);
        check("t5_fifth_read_after_return", 64'(count_g(GR)), 64'(MAX_PEND + 1));
        at_pos();
        ret_budget = -1;
        wait_drain("t5", 200, 1);
        check("t5_all_reads", 64'(count_g(GR)), 64'(6));

        // Spurious readdatavalid with nothing outstanding
        at_pos();
        base_v   = rd_valid_cnt;
        spurious = 1;
        repeat (4) @(negedge i_clk);
        at_pos();
        spurious = 0;
        repeat (3) @(negedge i_clk);
        check("t6_spurious_no_valid", 64'(rd_valid_cnt - base_v), 64'(0));

        // Two reads left outstanding, a third stuck in wait, then reset
        at_pos();
        ret_budget = 0;
        rd_todo.push_back(23'h000100);
        rd_todo.push_back(23'h000101);
        wait_drain("t6a", 60, 0);
        at_pos();
        hold_wait = 1;
        rd_todo.push_back(23'h000102);
        n = 0;
        while (o_avm_read_n && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) flag("t6_rd_cmd_timeout", n, 50);
        base_r = rd_ack_cnt;
        base_v = rd_valid_cnt;
        #2;
        i_rst = 1'b1;
        #1;
        check("t6_rst_read_n_immediate", 64'(o_avm_read_n), 64'(1));
        check("t6_rst_write_n_immediate", 64'(o_avm_write_n), 64'(1));
        rd_todo.delete();
        rd_addr_exp.delete();
        rd_data_exp.delete();
        pipe.delete();
        model_pend = 0;
        hold_wait  = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        check("t6_no_ack_after_rst", 64'(rd_ack_cnt - base_r), 64'(0));
        check("t6_no_valid_after_rst", 64'(rd_valid_cnt - base_v), 64'(0));

        // After reset the full read budget must be available again
        at_pos();
        grant_log.delete();
        for (int i = 0; i < MAX_PEND; i++) rd_todo.push_back(ADDR_W'($urandom));
        repeat (40) @(negedge i_clk);
        check("t6_pend_cleared_by_rst", 64'(count_g(GR)), 64'(MAX_PEND));
        at_pos();
        ret_budget = -1;
        wait_drain("t6b", 200, 1);

        // Randomised traffic
        at_pos();
        wait_pct = 30;
        rand_lat = 1;
        rand_gap = 1;
        base_w   = wr_ack_cnt;
        base_v   = rd_valid_cnt;
        for (int i = 0; i < 60; i++) begin
            push_wr(ADDR_W'($urandom), $urandom);
            rd_todo.push_back(ADDR_W'($urandom));
        end
        wait_drain("t7", 6000, 1);
        check("t7_wr_ack_total", 64'(wr_ack_cnt - base_w), 64'(60));
        check("t7_rd_valid_total", 64'(rd_valid_cnt - base_v), 64'(60));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #800000;
        flag("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-client arbiter in front of the single Avalon-MM SDRAM controller slave (`new_sdram_controller_0_s1`).
- Clients: a record-path writer and a playback-path reader.
- Lets recording and playback share the SDRAM concurrently, e.g. for monitor/overdub.
- Issues one command at a time, tracks outstanding pipelined reads and routes returned data to the reader.

Parameters:
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, SDRAM data width (two packed 16-bit samples)
- MAX_PEND, 4, maximum outstanding reads; 1..15

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_wr_req  in  1  writer request; held until o_wr_ack
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_W  write data
- o_wr_ack  out  1  one-cycle pulse: write accepted by SDRAM
- i_rd_req  in  1  reader request; held until o_rd_ack
- i_rd_addr  in  ADDR_W  read address
- o_rd_ack  out  1  one-cycle pulse: read command accepted
- o_rd_data  out  DATA_W  returned read data
- o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
- o_avm_address  out  ADDR_W  SDRAM address
- o_avm_chipselect  out  1  tied 1
- o_avm_byteenable_n  out  4  tied 0
- o_avm_read_n  out  1  active-low read
- o_avm_write_n  out  1  active-low write
- o_avm_writedata  out  DATA_W  write data
- i_avm_readdata  in  DATA_W  read data
- i_avm_readdatavalid  in  1  read data strobe
- i_avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: reset is i_rst, asynchronous, active-high; clock is i_clk.
- Reset values: state IDLE; o_avm_read_n=1, o_avm_write_n=1; address/writedata 0; o_wr_ack=o_rd_ack=o_rd_valid=0; o_rd_data=0; pend_cnt=0; last_grant=RD (so the first tie goes to the writer).
- All outputs registered except the two tied constants.
- FSM IDLE:
  - Eligible writer: i_wr_req.
  - Eligible reader: i_rd_req && pend_cnt<MAX_PEND.
  - One eligible: grant it.
  - Both eligible: round-robin, i.e. grant the client opposite last_grant.
  - On grant: register address/data, drive write_n=0 (WR) or read_n=0 (RD) next cycle, update last_grant.
- FSM WR / RD:
  - Hold address, data and strobe stable while i_avm_waitrequest=1.
  - On the first cycle with waitrequest=0: command accepted. Deassert strobe next cycle, pulse the matching ack next cycle, return to IDLE.
  - An RD acceptance increments pend_cnt.
  - Minimum 3 cycles from grant to next grant; no back-to-back commands.
- Read return:
  - When i_avm_readdatavalid=1 and pend_cnt>0: o_rd_data<=i_avm_readdata, o_rd_valid=1 next cycle, pend_cnt decrements.
  - Data returns in issue order; no tagging.
  - Accept and return in the same cycle: pend_cnt unchanged.
  - readdatavalid with pend_cnt=0 (spurious, or post-reset stale data): ignored; no o_rd_valid, pend_cnt stays 0.
- Boundaries:
  - pend_cnt==MAX_PEND: reader ineligible; writer still served.
  - pend_cnt never exceeds MAX_PEND nor underflows.
  - Request dropped while waiting in IDLE: no grant.
  - Once granted, the command completes regardless of the request level.
  - Address is passed through unmodified; clients own wrap-around.
- Reset mid-command: strobes deassert immediately (async), pend_cnt clears, the command is abandoned with no ack.

Optional Feature:
- Macro: SDRAM_ARB_WRPRIO_EN.
- Defined: strict write priority. Writer always wins a tie, so record never drops samples; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Single write (waitrequest=0): wr_req, addr=0x000010, data=0xAAAA5555 -> write_n=0 one cycle with those values; o_wr_ack pulses 1 cycle later; state IDLE.
- Write with waitrequest high 5 cycles -> write_n, address and data stable all 5+1 cycles; exactly one o_wr_ack.
- Read, slave returns 0x12345678 three cycles after acceptance -> o_rd_ack one pulse; o_rd_valid one pulse with o_rd_data=0x12345678; pend_cnt back to 0.
- Both requests held continuously for 8 grants -> grants alternate W,R,W,R,... starting with W. With SDRAM_ARB_WRPRIO_EN -> all W until wr_req drops.
- Readdatavalid suppressed, 6 reads requested (MAX_PEND=4) -> exactly 4 read commands; reader blocked while a concurrent write is still served; one return -> 5th read issues.
- Spurious readdatavalid at pend_cnt=0, and i_rst asserted during RD with waitrequest=1 -> no o_rd_valid; read_n=1 immediately; pend_cnt=0; no ack.
